load_store_stage: RTL
=====================

Name: load_store_stage

Overview:
- Pipelined MEM stage that replaces the pass-through memory stage between EXECUTION and register writeback.
- Adds a word-addressed data memory serving lw/sw with a configurable number of wait states.
- While an access is in flight, it freezes the upstream pipeline through a Stall output.
- Drives the MW_* writeback bus consumed by INSTRUCTION_DECODE: either the ALU result or the load data.

Parameters:
- DMEM_DEPTH, 256: number of 32-bit words in the data memory.
- ADDR_W, 8: word-address width; log2(DMEM_DEPTH).
- WAIT_CYCLES, 2: extra cycles per memory access; 0 gives single-cycle access.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- XM_RD  in  5  destination register from EXECUTION.
- ALUout  in  32  ALU result; byte address for lw/sw.
- XM_StoreData  in  32  rt value to store.
- XM_MemRead  in  1  lw in this stage.
- XM_MemWrite  in  1  sw in this stage.
- XM_RegWrite  in  1  register-write enable from EXECUTION.
- MW_RD  out  5  writeback destination, registered.
- MW_ALUout  out  32  writeback value (load data or ALUout), registered.
- MW_RegWrite  out  1  writeback enable, registered.
- Stall  out  1  combinational; 1 means IF/ID/EXE and the XM_* inputs must hold.
- Misalign  out  1  registered 1-cycle pulse on a misaligned lw/sw.

Behaviour:
- Reset:
  - MW_RD=0, MW_ALUout=0, MW_RegWrite=0, Misalign=0, state=IDLE, cnt=0.
  - Memory contents are not reset.
  - Reset during ACCESS aborts the access; no write is committed.
- Word address = ALUout[ADDR_W+1:2]. Higher bits are ignored, so addresses wrap modulo DMEM_DEPTH.
- MemOp = XM_MemRead | XM_MemWrite.
- FSM states: IDLE, ACCESS. cnt is a down-counter of width clog2(WAIT_CYCLES+1).
- IDLE, no MemOp:
  - MW_RD<=XM_RD, MW_ALUout<=ALUout, MW_RegWrite<=XM_RegWrite.
  - Stall=0.
- IDLE, MemOp, WAIT_CYCLES=0:
  - Access completes this cycle; same update as the ACCESS completion case below.
  - Stall=0.
- IDLE, MemOp, WAIT_CYCLES>0:
  - Stall=1, cnt<=WAIT_CYCLES, state<=ACCESS.
  - Bubble inserted: MW_RegWrite<=0; MW_RD and MW_ALUout hold.
- ACCESS, cnt>1:
  - Stall=1, cnt<=cnt-1, bubble (MW_RegWrite<=0).
- ACCESS, cnt==1 (completion):
  - Stall=0.
  - Write: if XM_MemWrite, mem[addr]<=XM_StoreData.
  - Writeback: MW_ALUout<=mem[addr] if load, else ALUout; MW_RD<=XM_RD; MW_RegWrite<=XM_RegWrite.
  - state<=IDLE.
- Total occupancy per memory op is WAIT_CYCLES+1 cycles; non-memory ops take 1 cycle.
- Back-to-back memory ops: the IDLE cycle after completion sees the next op and restarts the sequence. There are no idle gaps beyond the wait states.
- Read timing: memory read is combinational. The value of a store completing in cycle N is visible to a load completing in cycle N+1 or later.
- XM_MemRead and XM_MemWrite both high is illegal:
  - Treated as a store.
  - MW_ALUout<=ALUout (no load data).
- Misaligned access (ALUout[1:0]!=0 with MemOp):
  - Full wait sequence still runs.
  - At completion, the store is suppressed; a load returns 0.
  - Misalign<=1 for exactly one cycle; MW_RegWrite passes through unchanged.
- Stall is combinational from state, cnt and MemOp only. It has no path from memory data.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W=32, REG_ADDR_W=5.
  - LS_IDLE/LS_ACCESS state encoding.
- Sub-module dmem_array:
  - Single port, parameterised by DMEM_DEPTH/ADDR_W.
  - Synchronous write enable, asynchronous read.
  - load_store_stage instantiates it and owns the FSM, counter and MW registers.

Test Plan:
- Reset, then ALU op: rst=1 for 2 cycles, then XM_RD=3, ALUout=0x1234, XM_RegWrite=1, no MemOp.
  -> After reset all outputs are 0; next cycle MW_RD=3, MW_ALUout=0x1234, MW_RegWrite=1, Stall=0 throughout.
- Store then load, WAIT_CYCLES=2: sw ALUout=0x10, XM_StoreData=0xDEADBEEF, then lw ALUout=0x10, XM_RD=5.
  -> Stall high 2 cycles per op.
  -> MW_RegWrite=0 during the bubbles.
  -> On lw completion, MW_RD=5 and MW_ALUout=0xDEADBEEF, with the total sequence taking 6 cycles.
- WAIT_CYCLES=0 build, same sw/lw pair.
  -> Stall never asserts; the load result appears 1 cycle after the lw is presented.
- Misaligned store: sw ALUout=0x13, XM_StoreData=0x55, then lw ALUout=0x10.
  -> Misalign pulses once.
  -> mem[4] is unchanged, so the following lw reads the old word.
- Reset mid-access: sw ALUout=0x20, XM_StoreData=0xAA; assert rst in the first ACCESS cycle.
  -> Stall drops, state returns to IDLE.
  -> A later lw of 0x20 returns the prior contents, not 0xAA.
- Address wrap, DMEM_DEPTH=256: sw ALUout=0x400, XM_StoreData=0x77, then lw ALUout=0x0.
  -> The lw returns 0x77.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths and load/store stage state encoding
package cpu_pkg;
    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [0:0] LS_IDLE   = 1'b0;
    localparam logic [0:0] LS_ACCESS = 1'b1;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word memory with synchronous write and asynchronous read
module dmem_array
    import cpu_pkg::*;
#(
    parameter int DMEM_DEPTH = 256,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DMEM_DEPTH];
    // commit a write at the clock edge; contents are never reset
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end
    assign rdata = mem[addr];
endmodule

// File: rtl/load_store_stage.sv
// load_store_stage: MEM stage with wait-stated data memory, upstream stall and writeback registers
module load_store_stage
    import cpu_pkg::*;
#(
    parameter int DMEM_DEPTH  = 256,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] XM_RD,
    input  logic [DATA_W-1:0]     ALUout,
    input  logic [DATA_W-1:0]     XM_StoreData,
    input  logic                  XM_MemRead,
    input  logic                  XM_MemWrite,
    input  logic                  XM_RegWrite,
    output logic [REG_ADDR_W-1:0] MW_RD,
    output logic [DATA_W-1:0]     MW_ALUout,
    output logic                  MW_RegWrite,
    output logic                  Stall,
    output logic                  Misalign
);
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    logic [0:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [REG_ADDR_W-1:0] mw_rd_q, mw_rd_d;
    logic [DATA_W-1:0]     mw_alu_q, mw_alu_d;
    logic                  mw_rw_q, mw_rw_d;
    logic                  misalign_q, misalign_d;
    logic                  mem_op, misaligned, done, mem_we, is_load;
    logic [DATA_W-1:0]     rdata;
    assign mem_op     = XM_MemRead | XM_MemWrite;
    assign misaligned = |ALUout[1:0];
    assign is_load    = XM_MemRead & ~XM_MemWrite;
    assign done       = (state_q == LS_ACCESS) ? (cnt_q == CNT_W'(1)) : (mem_op && WAIT_CYCLES == 0);
    assign mem_we     = done & XM_MemWrite & ~misaligned & ~rst;
    assign Stall      = (state_q == LS_IDLE) ? (mem_op && WAIT_CYCLES != 0) : (cnt_q != CNT_W'(1));
    dmem_array #(.DMEM_DEPTH(DMEM_DEPTH), .ADDR_W(ADDR_W)) u_dmem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (ALUout[ADDR_W+1:2]),
        .wdata (XM_StoreData),
        .rdata (rdata)
    );
    // next state: complete an access, count down wait states, start an access, or pass an ALU op through
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mw_rd_d    = mw_rd_q;
        mw_alu_d   = mw_alu_q;
        mw_rw_d    = mw_rw_q;
        misalign_d = 1'b0;
        if (done) begin
            state_d    = LS_IDLE;
            cnt_d      = '0;
            mw_rd_d    = XM_RD;
            mw_alu_d   = is_load ? (misaligned ? '0 : rdata) : ALUout;
            mw_rw_d    = XM_RegWrite;
            misalign_d = misaligned;
        end else if (state_q == LS_ACCESS) begin
            cnt_d   = cnt_q - CNT_W'(1);
            mw_rw_d = 1'b0;
        end else if (mem_op) begin
            state_d = LS_ACCESS;
            cnt_d   = CNT_W'(WAIT_CYCLES);
            mw_rw_d = 1'b0;
        end else begin
            mw_rd_d  = XM_RD;
            mw_alu_d = ALUout;
            mw_rw_d  = XM_RegWrite;
        end
    end
    // state and writeback registers; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LS_IDLE;
            cnt_q      <= '0;
            mw_rd_q    <= '0;
            mw_alu_q   <= '0;
            mw_rw_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mw_rd_q    <= mw_rd_d;
            mw_alu_q   <= mw_alu_d;
            mw_rw_q    <= mw_rw_d;
            misalign_q <= misalign_d;
        end
    end
    assign MW_RD       = mw_rd_q;
    assign MW_ALUout   = mw_alu_q;
    assign MW_RegWrite = mw_rw_q;
    assign Misalign    = misalign_q;
endmodule
